// File: rtl/issue_ctrl.sv
// Purpose : issue sequencer between decoder and execute; load/CSR scoreboard, hazard stall, serialization.
// Latency : 1 cycle from decode accept to iss_valid (registered issue slot).
// Backpr. : dec_ready drops while the issue slot is held (iss_ready=0), on hazards, full counter or serialization.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush           kill issue register and serialization state (scoreboard kept)
//   dec_*           decoded instruction (valid/ready handshake, dec_ready is combinational)
//   iss_*           registered issue port (valid/ready)
//   wb_valid/wb_rd  long-latency writeback completion
//   ser_done        serializing instruction retired
//   stall_cause     0 none, 1 hazard, 2 outstanding full, 3 serialize
//   outstanding     long-latency ops in flight
//
// Optional feature: define ISSUE_WB_BYPASS_EN to let a same-cycle writeback
// clear the hazard / full condition (zero-bubble issue after writeback).
// Without it, hazard and full use registered state only (one stall cycle).

module issue_ctrl #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       dec_valid,
    output logic       dec_ready,
    input  logic [4:0] dec_rs1,
    input  logic       dec_rs1_valid,
    input  logic [4:0] dec_rs2,
    input  logic       dec_rs2_valid,
    input  logic [4:0] dec_rd,
    input  logic       dec_rd_valid,
    input  logic [5:0] dec_instr_id,
    output logic       iss_valid,
    input  logic       iss_ready,
    output logic [5:0] iss_instr_id,
    output logic [4:0] iss_rd,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    input  logic       ser_done,
    output logic [1:0] stall_cause,
    output logic [3:0] outstanding
);

    // Instruction IDs (shared encoding with the decoder).
    localparam logic [5:0] INSTR_INVALID = 6'd0;
    localparam logic [5:0] INSTR_LB      = 6'd10;
    localparam logic [5:0] INSTR_LH      = 6'd11;
    localparam logic [5:0] INSTR_LW      = 6'd12;
    localparam logic [5:0] INSTR_LBU     = 6'd13;
    localparam logic [5:0] INSTR_LHU     = 6'd14;
    localparam logic [5:0] INSTR_ECALL   = 6'd20;
    localparam logic [5:0] INSTR_EBREAK  = 6'd21;
    localparam logic [5:0] INSTR_MRET    = 6'd22;
    localparam logic [5:0] INSTR_FENCE_I = 6'd23;
    localparam logic [5:0] INSTR_CSRRW   = 6'd24;
    localparam logic [5:0] INSTR_CSRRS   = 6'd25;
    localparam logic [5:0] INSTR_CSRRC   = 6'd26;
    localparam logic [5:0] INSTR_CSRRWI  = 6'd27;
    localparam logic [5:0] INSTR_CSRRSI  = 6'd28;
    localparam logic [5:0] INSTR_CSRRCI  = 6'd29;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_HAZARD = 2'd1;
    localparam logic [1:0] CAUSE_FULL   = 2'd2;
    localparam logic [1:0] CAUSE_SER    = 2'd3;

    typedef struct packed {
        logic [5:0] instr_id;
        logic [4:0] rd;
    } iss_t;

    typedef enum logic {
        RUN  = 1'b0,
        SERW = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    iss_t        iss_q;
    logic        iss_vld_q;
    logic [31:0] pending_q;
    logic [31:0] pending_d;
    logic [3:0]  cnt_q;

    logic        is_csr;
    logic        is_long;
    logic        is_ser;
    logic [31:0] wb_mask;
    logic [31:0] pending_eff;
    logic [3:0]  cnt_eff;
    logic        hazard;
    logic        full;
    logic        ser_drain;
    logic        slot_free;
    logic        accept;
    logic        cnt_inc;
    logic        cnt_dec;

    // ------------------------------------------------------------------
    // Instruction classification
    // ------------------------------------------------------------------
    always_comb begin
        is_csr  = (dec_instr_id >= INSTR_CSRRW) && (dec_instr_id <= INSTR_CSRRCI);
        is_long = ((dec_instr_id >= INSTR_LB) && (dec_instr_id <= INSTR_LHU)) || is_csr;
        is_ser  = (dec_instr_id == INSTR_ECALL)   || (dec_instr_id == INSTR_EBREAK) ||
                  (dec_instr_id == INSTR_MRET)    || (dec_instr_id == INSTR_FENCE_I) ||
                  (dec_instr_id == INSTR_INVALID) || is_csr;
    end

    // Unused-id sanity: LW sits inside the load range; kept for readability.
    logic unused_ids;
    assign unused_ids = (INSTR_LW == 6'd0);

    // ------------------------------------------------------------------
    // Hazard / full / serialization evaluation
    // ------------------------------------------------------------------
    assign wb_mask = wb_valid ? (32'd1 << wb_rd) : 32'd0;

`ifdef ISSUE_WB_BYPASS_EN
    // A writeback landing this cycle already resolves the dependency.
    assign pending_eff = pending_q & ~wb_mask;
    assign cnt_eff     = (wb_valid && (cnt_q != 4'd0)) ? (cnt_q - 4'd1) : cnt_q;
`else
    assign pending_eff = pending_q;
    assign cnt_eff     = cnt_q;
`endif

    assign hazard = (dec_rs1_valid & pending_eff[dec_rs1]) |
                    (dec_rs2_valid & pending_eff[dec_rs2]) |
                    (dec_rd_valid  & pending_eff[dec_rd]);

    assign full = is_long & (cnt_eff == MAX_CNT);

    // Serializing instructions wait for every long-latency op to drain.
    assign ser_drain = is_ser & (cnt_q != 4'd0);

    assign slot_free = ~iss_vld_q | iss_ready;

    assign dec_ready = slot_free & (state_q == RUN) & ~hazard & ~full & ~ser_drain & ~flush;
    assign accept    = dec_valid & dec_ready;

    always_comb begin
        stall_cause = CAUSE_NONE;
        if (dec_valid && !dec_ready) begin
            if ((state_q != RUN) || ser_drain) begin
                stall_cause = CAUSE_SER;
            end else if (hazard) begin
                stall_cause = CAUSE_HAZARD;
            end else if (full) begin
                stall_cause = CAUSE_FULL;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialization FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (accept && is_ser) state_d = SERW;
                SERW:    if (ser_done)         state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_vld_q      <= 1'b0;
            iss_q.instr_id <= INSTR_INVALID;
            iss_q.rd       <= 5'd0;
        end else if (flush) begin
            iss_vld_q <= 1'b0;
        end else if (accept) begin
            iss_vld_q      <= 1'b1;
            iss_q.instr_id <= dec_instr_id;
            iss_q.rd       <= dec_rd_valid ? dec_rd : 5'd0;
        end else if (iss_ready) begin
            iss_vld_q <= 1'b0;
        end
    end

    assign iss_valid    = iss_vld_q;
    assign iss_instr_id = iss_q.instr_id;
    assign iss_rd       = iss_q.rd;

    // ------------------------------------------------------------------
    // Register scoreboard: set wins over a same-cycle clear; x0 never pends.
    // Flush does not touch it, since in-flight loads still write back.
    // ------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q & ~wb_mask;
        if (accept && is_long && dec_rd_valid && (dec_rd != 5'd0)) begin
            pending_d[dec_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 32'd0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding counter: a writeback with nothing in flight is dropped,
    // which also absorbs stray writebacks arriving after a reset.
    // ------------------------------------------------------------------
    assign cnt_inc = accept & is_long;
    assign cnt_dec = wb_valid & (cnt_q != 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else if (cnt_inc && !cnt_dec) begin
            cnt_q <= cnt_q + 4'd1;
        end else if (cnt_dec && !cnt_inc) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign outstanding = cnt_q;

endmodule
